// File: rtl/systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : systolic_array_ctrl
//  Purpose  : Sequencer for an output-stationary systolic array. It clears
//             the PE accumulators, generates skewed row/column operand-feed
//             enables, waits for the pipeline to drain, and then unloads one
//             result row per valid/ready beat.
//  Revision : 1.0 - initial release
// ============================================================================
module systolic_array_ctrl #(
   parameter int LEFT_MATRIX_ROW  = 4,
   parameter int INNER_DIMENSION  = 4,
   parameter int RIGHT_MATRIX_COL = 4,
   parameter int PE_LATENCY       = 1
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   start,
   input  logic                                   abort,
   output logic                                   busy,
   output logic                                   done,
   output logic                                   pe_clear,
   output logic [LEFT_MATRIX_ROW-1:0]             a_feed_vld,
   output logic [RIGHT_MATRIX_COL-1:0]            b_feed_vld,
   output logic [$clog2(LEFT_MATRIX_ROW+RIGHT_MATRIX_COL+INNER_DIMENSION)-1:0] feed_step,
   output logic [(LEFT_MATRIX_ROW > 1 ? $clog2(LEFT_MATRIX_ROW) : 1)-1:0]      res_row,
   output logic                                   res_valid,
   input  logic                                   res_ready
);

   // Counter widths: skew step must hold T-1, row index at least one bit,
   // drain counter only as wide as PE_LATENCY requires.
   localparam int c_SW = $clog2(LEFT_MATRIX_ROW + RIGHT_MATRIX_COL + INNER_DIMENSION);
   localparam int c_RW = (LEFT_MATRIX_ROW > 1) ? $clog2(LEFT_MATRIX_ROW) : 1;
   localparam int c_DW = (PE_LATENCY > 1) ? $clog2(PE_LATENCY) : 1;
   // Number of skewed feed steps: the last row/column starts M-1 / N-1 late
   // and needs K cycles, so the wavefront spans K+M+N-2 steps.
   localparam int c_T  = INNER_DIMENSION + LEFT_MATRIX_ROW + RIGHT_MATRIX_COL - 2;

   localparam logic [c_SW-1:0] c_STEP_LAST  = c_SW'(c_T - 1);
   localparam logic [c_DW-1:0] c_DRAIN_LAST = c_DW'(PE_LATENCY - 1);
   localparam logic [c_RW-1:0] c_ROW_LAST   = c_RW'(LEFT_MATRIX_ROW - 1);
   localparam logic [31:0]     c_K          = 32'(INNER_DIMENSION);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_CLEAR  = 3'd1,
      S_FEED   = 3'd2,
      S_DRAIN  = 3'd3,
      S_UNLOAD = 3'd4,
      S_DONE   = 3'd5
   } state_t;

   state_t            state_q, state_d;
   logic [c_SW-1:0]   step_q,  step_d;
   logic [c_DW-1:0]   drain_q, drain_d;
   logic [c_RW-1:0]   row_q,   row_d;

   logic              w_feeding;
   logic [31:0]       w_t;

   // State and counter registers; async reset returns straight to IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         step_q  <= '0;
         drain_q <= '0;
         row_q   <= '0;
      end else begin
         state_q <= state_d;
         step_q  <= step_d;
         drain_q <= drain_d;
         row_q   <= row_d;
      end
   end

   // Next-state, counter updates and state-decoded outputs; abort overrides all.
   always_comb begin
      state_d   = state_q;
      step_d    = step_q;
      drain_d   = drain_q;
      row_d     = row_q;
      busy      = 1'b1;
      done      = 1'b0;
      pe_clear  = 1'b0;
      feed_step = '0;
      res_row   = '0;
      res_valid = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start) begin
               state_d = S_CLEAR;
            end
         end
         S_CLEAR: begin
            pe_clear = 1'b1;
            step_d   = '0;
            state_d  = S_FEED;
         end
         S_FEED: begin
            feed_step = step_q;
            if (step_q == c_STEP_LAST) begin
               drain_d = '0;
               state_d = S_DRAIN;
            end else begin
               step_d = step_q + c_SW'(1);
            end
         end
         S_DRAIN: begin
            if (drain_q == c_DRAIN_LAST) begin
               row_d   = '0;
               state_d = S_UNLOAD;
            end else begin
               drain_d = drain_q + c_DW'(1);
            end
         end
         S_UNLOAD: begin
            res_valid = 1'b1;
            res_row   = row_q;
            if (res_ready) begin
               if (row_q == c_ROW_LAST) begin
                  state_d = S_DONE;
               end else begin
                  row_d = row_q + c_RW'(1);
               end
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      if (abort) begin
         state_d = S_IDLE;
      end
   end

   assign w_feeding = (state_q == S_FEED);
   assign w_t       = 32'(step_q);

   // Row i is live for t in [i, i+K-1]; the unsigned difference wraps to a
   // large value when t < i, so a single compare covers both bounds.
   generate
      for (genvar i = 0; i < LEFT_MATRIX_ROW; i++) begin : g_a_mask
         localparam logic [31:0] c_IDX = 32'(i);
         assign a_feed_vld[i] = w_feeding && ((w_t - c_IDX) < c_K);
      end
      for (genvar j = 0; j < RIGHT_MATRIX_COL; j++) begin : g_b_mask
         localparam logic [31:0] c_IDX = 32'(j);
         assign b_feed_vld[j] = w_feeding && ((w_t - c_IDX) < c_K);
      end
   endgenerate

endmodule
`default_nettype wire

// File: tb/tb_systolic_array_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_systolic_array_ctrl
//  Purpose  : Self-checking bench for systolic_array_ctrl. Two instances
//             (4x4x4/PE_LATENCY=1 and 1x3x2/PE_LATENCY=3) are compared cycle
//             by cycle against a phase model derived from operation timing.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_systolic_array_ctrl;

   localparam int LIMIT = 1000;

   int PM [2] = '{4, 1};
   int PK [2] = '{4, 2};
   int PN [2] = '{4, 3};
   int PL [2] = '{1, 3};
   bit pat [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};

   logic clk;
   logic rst_n;
   logic start_s [2];
   logic abort_s [2];
   logic ready_s [2];

   logic        busy0, done0, clr0, valid0;
   logic [3:0]  a0, b0, step0;
   logic [1:0]  row0;
   logic        busy1, done1, clr1, valid1;
   logic [0:0]  a1;
   logic [2:0]  b1, step1;
   logic [0:0]  row1;

   logic [31:0] o_busy [2], o_done [2], o_clr [2], o_valid [2];
   logic [31:0] o_a [2], o_b [2], o_step [2], o_row [2];

   int errors = 0;
   int checks = 0;

   systolic_array_ctrl #(
      .LEFT_MATRIX_ROW(4), .INNER_DIMENSION(4), .RIGHT_MATRIX_COL(4), .PE_LATENCY(1)
   ) u_dut0 (
      .clk(clk), .rst_n(rst_n), .start(start_s[0]), .abort(abort_s[0]),
      .busy(busy0), .done(done0), .pe_clear(clr0), .a_feed_vld(a0),
      .b_feed_vld(b0), .feed_step(step0), .res_row(row0), .res_valid(valid0),
      .res_ready(ready_s[0])
   );

   systolic_array_ctrl #(
      .LEFT_MATRIX_ROW(1), .INNER_DIMENSION(2), .RIGHT_MATRIX_COL(3), .PE_LATENCY(3)
   ) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start_s[1]), .abort(abort_s[1]),
      .busy(busy1), .done(done1), .pe_clear(clr1), .a_feed_vld(a1),
      .b_feed_vld(b1), .feed_step(step1), .res_row(row1), .res_valid(valid1),
      .res_ready(ready_s[1])
   );

   assign o_busy[0]  = 32'(busy0);   assign o_busy[1]  = 32'(busy1);
   assign o_done[0]  = 32'(done0);   assign o_done[1]  = 32'(done1);
   assign o_clr[0]   = 32'(clr0);    assign o_clr[1]   = 32'(clr1);
   assign o_valid[0] = 32'(valid0);  assign o_valid[1] = 32'(valid1);
   assign o_a[0]     = 32'(a0);      assign o_a[1]     = 32'(a1);
   assign o_b[0]     = 32'(b0);      assign o_b[1]     = 32'(b1);
   assign o_step[0]  = 32'(step0);   assign o_step[1]  = 32'(step1);
   assign o_row[0]   = 32'(row0);    assign o_row[1]   = 32'(row1);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp_v);
      end
   endtask

   task automatic chk_idle(input int d, input string tag);
      chk({tag, "_busy"},  o_busy[d],  32'd0);
      chk({tag, "_done"},  o_done[d],  32'd0);
      chk({tag, "_clr"},   o_clr[d],   32'd0);
      chk({tag, "_a"},     o_a[d],     32'd0);
      chk({tag, "_b"},     o_b[d],     32'd0);
      chk({tag, "_step"},  o_step[d],  32'd0);
      chk({tag, "_valid"}, o_valid[d], 32'd0);
      chk({tag, "_row"},   o_row[d],   32'd0);
   endtask

   // One operation on instance d, called at a negedge with the DUT idle.
   // abort_at: cycle index (1 = CLEAR) at which abort is raised, -1 for none.
   // rst_row : result row at which rst_n is pulled low, -1 for none.
   // rmode   : 0 ready always 1, 1 random ready, 2 fixed ready pattern.
   task automatic run_op(input int d, input int abort_at, input int rst_row, input int rmode);
      int m, n, k, pl, tl, c, beats, pi, t;
      bit fin, rdy;
      logic [31:0] ea, eb, e_clr, e_step, e_valid, e_row, e_done;
      m = PM[d]; n = PN[d]; k = PK[d]; pl = PL[d];
      tl = k + m + n - 2;
      chk("pre_busy", o_busy[d], 32'd0);
      start_s[d] = 1'b1;
      @(negedge clk);
      start_s[d] = 1'b0;
      c = 1; beats = 0; pi = 0; fin = 1'b0;
      while (!fin) begin
         ea = '0; eb = '0; e_clr = '0; e_step = '0;
         e_valid = '0; e_row = '0; e_done = '0;
         if (c == 1) begin
            e_clr = 32'd1;
         end else if (c <= tl + 1) begin
            t = c - 2;
            e_step = 32'(t);
            for (int i = 0; i < m; i++) if (t >= i && t <= i + k - 1) ea[i] = 1'b1;
            for (int j = 0; j < n; j++) if (t >= j && t <= j + k - 1) eb[j] = 1'b1;
         end else if (c <= tl + 1 + pl) begin
            e_step = '0;
         end else if (beats < m) begin
            e_valid = 32'd1;
            e_row   = 32'(beats);
         end else begin
            e_done = 32'd1;
         end
         chk("busy",  o_busy[d],  32'd1);
         chk("clear", o_clr[d],   e_clr);
         chk("a_vld", o_a[d],     ea);
         chk("b_vld", o_b[d],     eb);
         chk("step",  o_step[d],  e_step);
         chk("valid", o_valid[d], e_valid);
         chk("row",   o_row[d],   e_row);
         chk("done",  o_done[d],  e_done);

         if (rst_row >= 0 && e_valid == 32'd1 && beats == rst_row) begin
            #2 rst_n = 1'b0;
            #1 chk_idle(d, "async_rst");
            ready_s[d] = 1'b0;
            start_s[d] = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            chk_idle(d, "post_rst");
            return;
         end

         if (e_done == 32'd1) begin
            fin = 1'b1;
            start_s[d] = 1'b0;
         end else begin
            case (rmode)
               0:       rdy = 1'b1;
               1:       rdy = 1'($urandom_range(0, 1));
               default: begin
                  rdy = pat[pi % 7];
                  if (e_valid == 32'd1) pi++;
               end
            endcase
            ready_s[d] = rdy;
            if (e_valid == 32'd1 && rdy) beats++;
            start_s[d] = 1'($urandom_range(0, 1));
            if (c == abort_at) begin
               abort_s[d] = 1'b1;
               @(negedge clk);
               abort_s[d] = 1'b0;
               start_s[d] = 1'b0;
               chk_idle(d, "abort");
               return;
            end
         end
         @(negedge clk);
         c++;
         if (c > LIMIT) begin
            chk("timeout_cycles", 32'(c), 32'(LIMIT));
            fin = 1'b1;
         end
      end
      ready_s[d] = 1'b0;
      chk_idle(d, "after_done");
      @(negedge clk);
      chk("no_restart", o_busy[d], 32'd0);
   endtask

   initial begin
      rst_n = 1'b0;
      for (int d = 0; d < 2; d++) begin
         start_s[d] = 1'b0; abort_s[d] = 1'b0; ready_s[d] = 1'b0;
      end
      repeat (3) @(negedge clk);
      chk_idle(0, "reset0");
      chk_idle(1, "reset1");
      rst_n = 1'b1;
      @(negedge clk);

      // Nominal 4x4x4 with ready tied high.
      run_op(0, -1, -1, 0);
      // Backpressure with the 1,0,0,1,0,1,1 ready pattern.
      run_op(0, -1, -1, 2);
      // Abort at FEED t=5, then full nominal timing again.
      run_op(0, 7, -1, 1);
      run_op(0, -1, -1, 0);

      // abort wins over start in IDLE.
      start_s[0] = 1'b1; abort_s[0] = 1'b1;
      @(negedge clk);
      start_s[0] = 1'b0; abort_s[0] = 1'b0;
      chk_idle(0, "abort_vs_start");
      @(negedge clk);
      chk("abort_vs_start_hold", o_busy[0], 32'd0);

      // Asynchronous reset while res_row=2, then a normal operation.
      run_op(0, -1, 2, 0);
      run_op(0, -1, -1, 1);

      // Degenerate 1x3x2 instance with PE_LATENCY=3.
      run_op(1, -1, -1, 0);
      run_op(1, -1, -1, 1);

      // Randomized operations across both instances.
      for (int r = 0; r < 10; r++) begin
         int d, ab;
         d = int'($urandom_range(0, 1));
         ab = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 14)) : -1;
         repeat ($urandom_range(0, 3)) begin
            @(negedge clk);
            chk("gap_busy", o_busy[d], 32'd0);
         end
         run_op(d, ab, -1, 1);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
